// File: rtl/pipelined_adder_if.sv
// Operand/result handshake bundle for pipelined_adder.
// The source side owns the operands and out_ready; the adder owns in_ready and the results.
interface pipelined_adder_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             carry_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             carry_out;
    logic             overflow;

    modport master (
        output in_valid, a, b, carry_in, out_ready,
        input  in_ready, out_valid, sum, carry_out, overflow
    );

    modport slave (
        input  in_valid, a, b, carry_in, out_ready,
        output in_ready, out_valid, sum, carry_out, overflow
    );
endinterface

// File: rtl/pipelined_adder.sv
// Pipelined WIDTH-bit adder: one CW-bit chunk per stage, carry rippled through registers.
// A single global advance moves every stage (bubbles included), so a stalled output freezes the pipe.
module pipelined_adder #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input logic              clk,
    input logic              reset,
    pipelined_adder_if.slave bus
);
    localparam int CW = WIDTH / STAGES;

    logic adv;
    logic ovf_q;

    assign adv          = !bus.out_valid || bus.out_ready;
    assign bus.in_ready = adv;

    genvar k;
    for (k = 0; k < STAGES; k = k + 1) begin : g_stage
        // a_in/b_in hold the operand chunks not yet added; chunk k sits in the low CW bits
        localparam int PW = (STAGES - k) * CW;
        logic [PW-1:0]       a_in;
        logic [PW-1:0]       b_in;
        logic                c_in;
        logic                v_in;
        logic [CW:0]         add;
        logic [(k+1)*CW-1:0] s_d;
        logic                v_q;
        logic                c_q;
        logic [(k+1)*CW-1:0] s_q;

        if (k == 0) begin : g_src
            assign a_in = bus.a;
            assign b_in = bus.b;
            assign c_in = bus.carry_in;
            assign v_in = bus.in_valid;
            assign s_d  = add[CW-1:0];
        end else begin : g_src
            assign a_in = g_ops[k-1].a_q;
            assign b_in = g_ops[k-1].b_q;
            assign c_in = g_stage[k-1].c_q;
            assign v_in = g_stage[k-1].v_q;
            assign s_d  = {add[CW-1:0], g_stage[k-1].s_q};
        end

        assign add = {1'b0, a_in[CW-1:0]} + {1'b0, b_in[CW-1:0]} + {{CW{1'b0}}, c_in};

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                v_q <= 1'b0;
                c_q <= 1'b0;
                s_q <= '0;
            end else if (adv) begin
                v_q <= v_in;
                c_q <= add[CW];
                s_q <= s_d;
            end
        end
    end

    for (k = 0; k < STAGES - 1; k = k + 1) begin : g_ops
        logic [(STAGES-1-k)*CW-1:0] a_q;
        logic [(STAGES-1-k)*CW-1:0] b_q;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                a_q <= '0;
                b_q <= '0;
            end else if (adv) begin
                a_q <= g_stage[k].a_in[(STAGES-k)*CW-1:CW];
                b_q <= g_stage[k].b_in[(STAGES-k)*CW-1:CW];
            end
        end
    end

    // Carry into the MSB is a^b^sum at that bit; signed overflow is it XOR the carry out.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovf_q <= 1'b0;
        end else if (adv) begin
            ovf_q <= g_stage[STAGES-1].a_in[CW-1] ^ g_stage[STAGES-1].b_in[CW-1]
                   ^ g_stage[STAGES-1].add[CW-1] ^ g_stage[STAGES-1].add[CW];
        end
    end

    assign bus.out_valid = g_stage[STAGES-1].v_q;
    assign bus.sum       = g_stage[STAGES-1].s_q;
    assign bus.carry_out = g_stage[STAGES-1].c_q;
    assign bus.overflow  = ovf_q;
endmodule

// File: tb/tb_pipelined_adder.sv
// Directed bench for pipelined_adder: a 32-bit/4-stage instance and a 1-bit/1-stage instance.
module tb_pipelined_adder;
    localparam int W = 32;
    localparam int S = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pipelined_adder_if #(.WIDTH(W)) bus ();
    pipelined_adder_if #(.WIDTH(1)) bus1 ();

    pipelined_adder #(.WIDTH(W), .STAGES(S)) u_dut (.clk(clk), .reset(reset), .bus(bus));
    pipelined_adder #(.WIDTH(1), .STAGES(1)) u_dut1 (.clk(clk), .reset(reset), .bus(bus1));

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         ci;
        logic [W-1:0] s;
        logic         co;
        logic         ov;
    } vec_t;

    typedef struct {
        logic a;
        logic b;
        logic ci;
        logic s;
        logic co;
        logic ov;
    } bit_t;

    int n_cmp = 0;
    int n_bad = 0;

    logic [W-1:0] va [64];
    logic [W-1:0] vb [64];
    logic         vc [64];
    logic [W-1:0] es [64];
    logic         eco [64];
    logic         eov [64];
    int           q [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic model_fill(input int n);
        logic [W:0] full;
        for (int i = 0; i < n; i++) begin
            va[i] = $urandom;
            vb[i] = $urandom;
            vc[i] = 1'($urandom_range(1));
            full  = {1'b0, va[i]} + {1'b0, vb[i]} + {{W{1'b0}}, vc[i]};
            es[i]  = full[W-1:0];
            eco[i] = full[W];
            eov[i] = (va[i][W-1] == vb[i][W-1]) && (full[W-1] != va[i][W-1]);
        end
    endtask

    // Streams n operand sets; out_ready drops for stall_len cycles from cycle stall_at.
    task automatic run_stream(input int n, input int stall_at, input int stall_len, input string tag);
        int cyc = 0;
        int idx = 0;
        int got = 0;
        int first_out = -1;
        int last_out = -1;
        int k;
        logic         held_v = 1'b0;
        logic [W-1:0] held_s = '0;
        logic         held_co = 1'b0;
        logic         held_ov = 1'b0;
        q.delete();
        while (got < n && cyc < 300) begin
            bus.in_valid  = (idx < n);
            bus.a         = va[idx];
            bus.b         = vb[idx];
            bus.carry_in  = vc[idx];
            bus.out_ready = !(cyc >= stall_at && cyc < stall_at + stall_len);
            #1;
            if (bus.out_valid && !bus.out_ready) begin
                check({tag, " stall in_ready"}, 64'(bus.in_ready), 64'd0);
                if (held_v) begin
                    check({tag, " stall sum"}, 64'(bus.sum), 64'(held_s));
                    check({tag, " stall carry_out"}, 64'(bus.carry_out), 64'(held_co));
                    check({tag, " stall overflow"}, 64'(bus.overflow), 64'(held_ov));
                end
                held_v  = 1'b1;
                held_s  = bus.sum;
                held_co = bus.carry_out;
                held_ov = bus.overflow;
            end else begin
                held_v = 1'b0;
            end
            if (bus.out_valid && bus.out_ready) begin
                if (q.size() == 0) begin
                    check({tag, " unexpected result"}, 64'd1, 64'd0);
                end else begin
                    k = q.pop_front();
                    check({tag, " sum"}, 64'(bus.sum), 64'(es[k]));
                    check({tag, " carry_out"}, 64'(bus.carry_out), 64'(eco[k]));
                    check({tag, " overflow"}, 64'(bus.overflow), 64'(eov[k]));
                end
                if (first_out < 0) first_out = cyc;
                if (last_out >= 0 && stall_len == 0)
                    check({tag, " consecutive"}, 64'(cyc), 64'(last_out + 1));
                last_out = cyc;
                got++;
            end
            if (stall_len == 0)
                check({tag, " in_ready"}, 64'(bus.in_ready), 64'd1);
            if (bus.in_valid && bus.in_ready) begin
                q.push_back(idx);
                idx++;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        check({tag, " results received"}, 64'(got), 64'(n));
        if (stall_len == 0)
            check({tag, " first latency"}, 64'(first_out), 64'(S));
    endtask

    vec_t tbl [9];
    bit_t tb1 [8];

    initial begin
        int cnt;

        tbl[0] = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b0};
        tbl[1] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
        tbl[2] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1};
        tbl[3] = '{32'h0000_0000, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0, 1'b0};
        tbl[4] = '{32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0, 1'b0};
        tbl[5] = '{32'h0000_FFFF, 32'h0000_0001, 1'b0, 32'h0001_0000, 1'b0, 1'b0};
        tbl[6] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0};
        tbl[7] = '{32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1};
        tbl[8] = '{32'h00FF_00FF, 32'h0001_0001, 1'b0, 32'h0100_0100, 1'b0, 1'b0};

        tb1[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tb1[1] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        tb1[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        tb1[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        tb1[4] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tb1[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        tb1[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        tb1[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

        reset = 1'b1;
        bus.in_valid   = 1'b0;
        bus.a          = '0;
        bus.b          = '0;
        bus.carry_in   = 1'b0;
        bus.out_ready  = 1'b1;
        bus1.in_valid  = 1'b0;
        bus1.a         = '0;
        bus1.b         = '0;
        bus1.carry_in  = 1'b0;
        bus1.out_ready = 1'b1;

        #2;
        check("reset out_valid", 64'(bus.out_valid), 64'd0);
        check("reset in_ready", 64'(bus.in_ready), 64'd1);
        check("reset sum", 64'(bus.sum), 64'd0);
        check("reset carry_out", 64'(bus.carry_out), 64'd0);
        check("reset overflow", 64'(bus.overflow), 64'd0);
        check("reset w1 out_valid", 64'(bus1.out_valid), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // 1-bit full-adder truth table, one result per cycle
        for (int i = 0; i < 8; i++) begin
            bus1.in_valid = 1'b1;
            bus1.a        = tb1[i].a;
            bus1.b        = tb1[i].b;
            bus1.carry_in = tb1[i].ci;
            @(posedge clk);
            #1;
            check("w1 out_valid", 64'(bus1.out_valid), 64'd1);
            check("w1 sum", 64'(bus1.sum), 64'(tb1[i].s));
            check("w1 carry_out", 64'(bus1.carry_out), 64'(tb1[i].co));
            check("w1 overflow", 64'(bus1.overflow), 64'(tb1[i].ov));
        end
        bus1.in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("w1 drained", 64'(bus1.out_valid), 64'd0);

        for (int i = 0; i < 9; i++) begin
            va[i]  = tbl[i].a;
            vb[i]  = tbl[i].b;
            vc[i]  = tbl[i].ci;
            es[i]  = tbl[i].s;
            eco[i] = tbl[i].co;
            eov[i] = tbl[i].ov;
        end
        run_stream(9, 0, 0, "table");
        repeat (S) @(posedge clk);
        #1;

        model_fill(16);
        run_stream(16, 0, 0, "stream");
        repeat (S) @(posedge clk);
        #1;

        model_fill(12);
        run_stream(12, 8, 6, "backpressure");
        repeat (S) @(posedge clk);
        #1;
        check("idle out_valid", 64'(bus.out_valid), 64'd0);

        // Reset with one result at the output and three more in flight
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.in_valid = 1'b1;
            bus.a        = 32'(i * 256 + 1);
            bus.b        = 32'h1;
            bus.carry_in = 1'b0;
            @(posedge clk);
            #1;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        #1;
        check("pre-reset out_valid", 64'(bus.out_valid), 64'd1);
        check("pre-reset sum", 64'(bus.sum), 64'h2);
        #1;
        reset = 1'b1;
        #1;
        check("async reset out_valid", 64'(bus.out_valid), 64'd0);
        check("async reset sum", 64'(bus.sum), 64'd0);
        check("async reset in_ready", 64'(bus.in_ready), 64'd1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        bus.out_ready = 1'b1;
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) cnt++;
        end
        check("flushed results seen", 64'(cnt), 64'd0);

        bus.in_valid = 1'b1;
        bus.a        = 32'h0F0F_0F0F;
        bus.b        = 32'h0101_0101;
        bus.carry_in = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        cnt = 1;
        while (!bus.out_valid && cnt < 12) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        check("post-reset latency", 64'(cnt), 64'(S));
        check("post-reset sum", 64'(bus.sum), 64'h1010_1011);
        check("post-reset carry_out", 64'(bus.carry_out), 64'd0);
        check("post-reset overflow", 64'(bus.overflow), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
